// File: rtl/spi_reg_writer.sv
// SPI mode-0 target for the equalizer gain register bank.
// Turns 16-bit frames into one-cycle write strobes and serves reads from gain_bus.
module spi_reg_writer #(
    parameter int NUM_REGS    = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [8*NUM_REGS-1:0] gain_bus,
    output logic                  we,
    output logic [7:0]            addr,
    output logic [7:0]            data_in,
    output logic                  addr_err
);

    // state   | meaning
    // IDLE    | waiting for cs_n low (only once cs_n has been seen high)
    // CMD     | shifting R/W + 7-bit address
    // DATA    | shifting data in, TX byte out on MISO
    // DONE    | frame complete, SCLK ignored until cs_n high
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_s, cs_s, mosi_s, sclk_d;
    logic                   sclk_rise, sclk_fall;

    logic [1:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] rx_sr, tx_sr;
    logic       cmd_rd, cmd_ok, wr_pend, armed;
    logic [7:0] cmd_addr;

    logic [6:0] addr_next;
    logic       addr_next_ok;
    logic [7:0] gain_sel;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // Address as it will be after the 8th rising edge shifts in its last bit.
    assign addr_next    = {rx_sr[5:0], mosi_s};
    assign addr_next_ok = ({1'b0, addr_next} < 8'(NUM_REGS));

    always_comb begin
        gain_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_next == 7'(i)) gain_sel = gain_bus[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            cmd_rd   <= 1'b0;
            cmd_ok   <= 1'b0;
            cmd_addr <= '0;
            wr_pend  <= 1'b0;
            armed    <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            data_in  <= '0;
            addr_err <= 1'b0;
            spi_miso <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            we       <= wr_pend;
            wr_pend  <= 1'b0;
            if (wr_pend) begin
                addr    <= cmd_addr;
                data_in <= rx_sr;
            end
            if (cs_s) armed <= 1'b1;

            case (state)
                ST_IDLE: begin
                    bit_cnt  <= '0;
                    spi_miso <= 1'b0;
                    if (!cs_s && armed) state <= ST_CMD;
                end
                ST_CMD: begin
                    if (cs_s) begin
                        state <= ST_IDLE;
                    end else if (sclk_rise) begin
                        rx_sr   <= {rx_sr[6:0], mosi_s};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            cmd_rd   <= rx_sr[6];
                            cmd_addr <= {1'b0, addr_next};
                            cmd_ok   <= addr_next_ok;
                            tx_sr    <= (rx_sr[6] && addr_next_ok) ? gain_sel : 8'h00;
                            if (rx_sr[6] && !addr_next_ok) addr_err <= 1'b1;
                            state    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (cs_s) begin
                        state    <= ST_IDLE;
                        spi_miso <= 1'b0;
                    end else begin
                        if (sclk_fall) begin
                            spi_miso <= tx_sr[7];
                            tx_sr    <= {tx_sr[6:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            rx_sr   <= {rx_sr[6:0], mosi_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) begin
                                state <= ST_DONE;
                                if (!cmd_rd) begin
                                    if (cmd_ok) wr_pend  <= 1'b1;
                                    else        addr_err <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    if (cs_s) begin
                        state    <= ST_IDLE;
                        spi_miso <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
